// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM state encoding and window-depth helper for the Sobel frame controller.
package sobel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } sobel_state_t;

    // Pixels needed before the 3x3 window centre reaches (0,0); also the flush length.
    function automatic int fill_depth(input int img_w);
        return img_w + 1;
    endfunction

endpackage

// File: rtl/sobel_pos_cnt.sv
// sobel_pos_cnt: raster row/column tracker for output centres, with registered valid/border/sof/eol.
module sobel_pos_cnt #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic adv_i,
    output logic valid_o,
    output logic border_o,
    output logic sof_o,
    output logic eol_o
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic valid_q, valid_d, border_q, border_d, sof_q, sof_d, eol_q, eol_d;
    logic col_end, row_end, at_edge;

    always_comb begin
        col_end  = col_q == COL_LAST;
        row_end  = row_q == ROW_LAST;
        at_edge  = row_q == '0 || row_end || col_q == '0 || col_end;
        col_d    = clr_i ? '0 : adv_i ? (col_end ? '0 : col_q + COL_W'(1)) : col_q;
        row_d    = clr_i ? '0 : (adv_i && col_end) ? (row_end ? '0 : row_q + ROW_W'(1)) : row_q;
        valid_d  = adv_i;
        border_d = adv_i && at_edge;
        sof_d    = adv_i && row_q == '0 && col_q == '0;
        eol_d    = adv_i && col_end;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            col_q    <= '0;
            row_q    <= '0;
            valid_q  <= 1'b0;
            border_q <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            valid_q  <= valid_d;
            border_q <= border_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
        end
    end

    assign valid_o  = valid_q;
    assign border_o = border_q;
    assign sof_o    = sof_q;
    assign eol_o    = eol_q;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: sequences one Sobel frame (window fill, streaming, zero-padded flush)
// and drives the line-buffer datapath strobes plus registered output qualifiers.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic pix_valid,
    output logic pix_ready,
    output logic shift_en,
    output logic pad_sel,
    output logic out_valid,
    output logic out_border,
    output logic out_sof,
    output logic out_eol,
    output logic busy,
    output logic done
);

    localparam int FILL_DEPTH = fill_depth(IMG_W);
    localparam int PIX_W      = $clog2(IMG_W * IMG_H + 1);
    localparam int FL_W       = $clog2(FILL_DEPTH);
    localparam logic [PIX_W-1:0] FILL_LAST = PIX_W'(FILL_DEPTH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(IMG_W * IMG_H - 1);
    localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FILL_DEPTH - 1);

    sobel_state_t     state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;
    logic             done_q, done_d;
    logic             accept, produce, launch;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        pix_ready = state_q == S_FILL || state_q == S_RUN;
        pad_sel   = state_q == S_FLUSH;
        accept    = pix_valid && pix_ready;
        shift_en  = accept || pad_sel;
        produce   = (state_q == S_RUN && accept) || pad_sel;
        launch    = start && state_q == S_IDLE;
        done_d    = state_q == S_DONE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FILL;
                    pix_cnt_d = '0;
                    fl_cnt_d  = '0;
                end
            end
            S_FILL: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    state_d   = pix_cnt_q == FILL_LAST ? S_RUN : S_FILL;
                end
            end
            S_RUN: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    state_d   = pix_cnt_q == PIX_LAST ? S_FLUSH : S_RUN;
                end
            end
            S_FLUSH: begin
                fl_cnt_d = fl_cnt_q + FL_W'(1);
                state_d  = fl_cnt_q == FL_LAST ? S_DONE : S_FLUSH;
            end
            S_DONE: begin
                state_d   = S_IDLE;
                pix_cnt_d = '0;
                fl_cnt_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            fl_cnt_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
            done_q    <= done_d;
        end
    end

    assign busy = state_q != S_IDLE;
    assign done = done_q;

    sobel_pos_cnt #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) u_pos (
        .clock_i (clock),
        .reset_i (reset),
        .clr_i   (launch),
        .adv_i   (produce),
        .valid_o (out_valid),
        .border_o(out_border),
        .sof_o   (out_sof),
        .eol_o   (out_eol)
    );

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed table-driven bench for a 4x4 frame plus bubble and reset sequences.
module tb_sobel_frame_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int NCYC = 25;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic pix_valid = 1'b0;
    logic pix_ready, shift_en, pad_sel, out_valid, out_border, out_sof, out_eol, busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       st;
        logic       pv;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [NCYC];
    logic [8:0] obs;

    sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .shift_en  (shift_en),
        .pad_sel   (pad_sel),
        .out_valid (out_valid),
        .out_border(out_border),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clock);
        obs = {pix_ready, shift_en, pad_sel, out_valid, out_border, out_sof, out_eol, busy, done};
    endtask

    // Drive inputs just after a rising edge, sample mid-cycle, then advance one clock.
    task automatic cyc(input logic st, input logic pv);
        start = st;
        pix_valid = pv;
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic run_table(input string tag, input logic extra_start);
        for (int c = 0; c < NCYC; c++) begin
            cyc(tbl[c].st | (extra_start && c >= 1 && c <= 22), tbl[c].pv);
            chk($sformatf("%s cyc%0d {rdy,sh,pad,ov,bd,sof,eol,busy,done}", tag, c), int'(obs), int'(tbl[c].exp));
        end
    endtask

    function automatic logic [2:0] flags_for(input int k);
        int r, c;
        r = k / W;
        c = k % W;
        return {(r == 0 || r == H - 1 || c == 0 || c == W - 1), k == 0, c == W - 1};
    endfunction

    initial begin
        // Continuous frame: cycle 0 start, cycles 1-16 accept, 17-21 flush, 22 DONE, 23 done pulse.
        for (int c = 0; c < NCYC; c++) begin
            logic rdy, fl, ov;
            logic [2:0] f;
            rdy = c >= 1 && c <= 16;
            fl  = c >= 17 && c <= 21;
            ov  = c >= 7 && c <= 22;
            f   = ov ? flags_for(c - 7) : 3'b000;
            tbl[c].st  = c == 0;
            tbl[c].pv  = rdy;
            tbl[c].exp = {rdy, rdy | fl, fl, ov, f, c >= 1 && c <= 22, c == 23};
        end

        repeat (2) @(posedge clock);
        #1;
        sample();
        chk("reset state outputs", int'(obs), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        chk("idle after reset", int'(obs), 0);

        run_table("continuous", 1'b0);
        run_table("start_ignored", 1'b1);

        // Reset mid-RUN after 8 accepts.
        cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b1);
        pix_valid = 1'b1;
        #2 reset = 1'b1;
        sample();
        chk("mid-run reset outputs", int'(obs), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1);
            chk($sformatf("no resume cyc%0d", i), int'(obs), 0);
        end
        run_table("after_reset", 1'b0);

        // Bubbles: pix_valid alternates 1,0 until 16 accepts.
        begin
            int acc, n, budget;
            logic pv, prev_bubble, got_done;
            logic [2:0] f;
            acc = 0;
            n = 0;
            prev_bubble = 1'b0;
            got_done = 1'b0;
            cyc(1'b1, 1'b0);
            for (budget = 0; budget < 200 && !got_done; budget++) begin
                pv = acc < W * H && (budget % 2 == 0);
                cyc(1'b0, pv);
                if (prev_bubble)
                    chk($sformatf("bubble no output cyc%0d", budget), int'(obs[5]), 0);
                if (obs[5]) begin
                    f = flags_for(n);
                    chk($sformatf("bubble flags out%0d", n), int'(obs[4:2]), int'(f));
                    n++;
                end
                prev_bubble = !pv && obs[8];
                if (!pv && obs[8])
                    chk($sformatf("bubble no shift cyc%0d", budget), int'(obs[7]), 0);
                if (pv && obs[8]) acc++;
                got_done = obs[0];
            end
            chk("bubble output count", n, W * H);
            chk("bubble done seen", int'(got_done), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning pixels per line (legal range 3..4095).
REQ-002 SHALL have parameter IMG_H, default 64, meaning lines per frame (legal range 3..4095).
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on posedge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  frame start request, single-cycle pulse.
REQ-006 SHALL have port pix_valid  input  1  upstream pixel present.
REQ-007 SHALL have port pix_ready  output  1  controller accepts a pixel this cycle.
REQ-008 SHALL have port shift_en  output  1  advance window/line-buffer datapath by one pixel.
REQ-009 SHALL have port pad_sel  output  1  datapath injects 0 instead of the input pixel.
REQ-010 SHALL have port out_valid  output  1  datapath output is a real Sobel result this cycle.
REQ-011 SHALL have port out_border  output  1  current output's centre lies on a frame edge; consumer forces it to 0.
REQ-012 SHALL have port out_sof  output  1  first output of a frame.
REQ-013 SHALL have port out_eol  output  1  last output of a line.
REQ-014 SHALL have port busy  output  1  frame in progress (state not IDLE).
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last output.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, RUN, FLUSH, DONE.
REQ-017 SHALL move IDLE->FILL on start; start in any other state SHALL be ignored.
REQ-018 SHALL define accept = pix_valid & pix_ready; pix_ready SHALL be 1 only in FILL and RUN.
REQ-019 SHALL assert shift_en combinationally in every accept cycle and in every FLUSH cycle; pad_sel = 1 only in FLUSH.
REQ-020 SHALL stay in FILL for the first IMG_W+1 accepts, producing no outputs, then enter RUN.
REQ-021 SHALL stay in RUN until pixel IMG_W*IMG_H is accepted, then enter FLUSH; each RUN accept yields one output.
REQ-022 SHALL stay in FLUSH exactly IMG_W+1 cycles (no stall), each yielding one output, then enter DONE.
REQ-023 SHALL spend one cycle in DONE with done=1, then return to IDLE.
REQ-024 SHALL register outputs: out_valid asserts the cycle after each output-producing shift_en cycle (1-cycle latency, matching registered datapath).
REQ-025 SHALL track output centre row/column counters (0..IMG_H-1, 0..IMG_W-1), column wrapping to 0 and row incrementing at IMG_W-1.
REQ-026 SHALL assert out_border with out_valid when row==0, row==IMG_H-1, col==0 or col==IMG_W-1.
REQ-027 SHALL assert out_sof with out_valid at (0,0) and out_eol with out_valid at col==IMG_W-1.
REQ-028 SHALL produce exactly IMG_W*IMG_H outputs per frame, in raster order.
REQ-029 SHALL hold all counters and state when pix_valid=0 in FILL/RUN (bubbles insert no outputs).
REQ-030 SHALL size counters as $clog2 of their maximum count; no counter SHALL wrap unintentionally.

Reset
REQ-031 SHALL on reset (any time, incl. mid-frame) force state IDLE, all counters 0, and pix_ready, shift_en, pad_sel, out_valid, out_border, out_sof, out_eol, busy, done all 0.
REQ-032 SHALL require a new start after reset release; partial frames SHALL NOT resume.

Structure
REQ-033 SHALL place the FSM state enumeration and the FILL/FLUSH depth constant (IMG_W+1 expression) in shared package sobel_pkg.
REQ-034 SHALL use one sub-module, sobel_pos_cnt, holding the row/column counters and edge/sof/eol decode.

Verification (IMG_W=4, IMG_H=4)
REQ-035 SHALL cover continuous stream: start, 16 pixels with pix_valid=1 -> no out_valid for 5 accepts, 16 out_valid total, done 1 cycle after 16th output.
REQ-036 SHALL cover border flags: same frame -> out_border=0 only for centres (1,1),(1,2),(2,1),(2,2); out_sof on output 1; out_eol on outputs 4,8,12,16.
REQ-037 SHALL cover bubbles: pix_valid toggling 1,0 -> output count 16, no output in any bubble cycle, order unchanged.
REQ-038 SHALL cover flush: after 16th accept -> pix_ready=0, pad_sel=shift_en=1 for exactly 5 cycles.
REQ-039 SHALL cover reset mid-RUN after 8 accepts -> all outputs 0 next cycle, IDLE; new start gives a full 16-output frame.
REQ-040 SHALL cover start ignored while busy -> output count and timing identical to REQ-035.
